// File: rtl/note_event_tracker.sv
// Tracks debounced note runs from a per-frame note stream and queues
// (note, duration) events in a circular FIFO for a downstream consumer.
module note_event_tracker #(
    parameter int NOTE_W     = 8,
    parameter int DUR_W      = 8,
    parameter int DEPTH      = 16,
    parameter int MIN_FRAMES = 3,
    parameter int REST_CODE  = 0,
    parameter int KEEP_RESTS = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     frame_valid,
    input  logic [NOTE_W-1:0]        frame_note,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NOTE_W-1:0]        out_note,
    output logic [DUR_W-1:0]         out_dur,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic                     busy,
    output logic                     done
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CCW = (MIN_FRAMES < 2) ? 1 : $clog2(MIN_FRAMES + 1);
    localparam logic [DUR_W-1:0]  DUR_MAX = '1;
    localparam logic [DUR_W-1:0]  MIN_DUR = DUR_W'(MIN_FRAMES);
    localparam logic [CCW-1:0]    MIN_CNT = CCW'(MIN_FRAMES);
    localparam logic [NOTE_W-1:0] REST    = NOTE_W'(REST_CODE);

    typedef enum logic [1:0] {IDLE, TRACK, FLUSH} state_t;

    state_t              state, n_state;
    logic [NOTE_W-1:0]   cur_note, n_cur_note, cand, n_cand;
    logic [DUR_W-1:0]    cur_dur, n_cur_dur;
    logic                has_cur, n_has;
    logic [CCW-1:0]      cand_cnt, n_cnt, cnt_inc;
    logic                commit, push, pop;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [NOTE_W-1:0]   mem_note [DEPTH];
    logic [DUR_W-1:0]    mem_dur  [DEPTH];

    // Run/candidate next-state; the committed event is always the open run.
    always_comb begin
        n_state    = state;
        n_cur_note = cur_note;
        n_cur_dur  = cur_dur;
        n_has      = has_cur;
        n_cand     = cand;
        n_cnt      = cand_cnt;
        cnt_inc    = '0;
        commit     = 1'b0;
        case (state)
            IDLE: if (start) begin
                n_state   = TRACK;
                n_has     = 1'b0;
                n_cnt     = '0;
                n_cur_dur = '0;
            end
            TRACK: if (stop) begin
                n_state = FLUSH;
                commit  = has_cur;
                n_has   = 1'b0;
                n_cnt   = '0;
            end else if (frame_valid) begin
                if (has_cur && frame_note == cur_note) begin
                    n_cnt = '0;
                    if (cur_dur == DUR_MAX) begin
                        commit    = 1'b1;
                        n_cur_dur = DUR_W'(1);
                    end else begin
                        n_cur_dur = cur_dur + 1'b1;
                    end
                end else begin
                    cnt_inc = (frame_note == cand) ? cand_cnt + 1'b1 : CCW'(1);
                    n_cand  = frame_note;
                    if (cnt_inc == MIN_CNT) begin
                        commit     = has_cur;
                        n_cur_note = frame_note;
                        n_cur_dur  = MIN_DUR;
                        n_has      = 1'b1;
                        n_cnt      = '0;
                    end else begin
                        n_cnt = cnt_inc;
                    end
                end
            end
            default: n_state = IDLE;
        endcase
        if (KEEP_RESTS == 0 && cur_note == REST)
            commit = 1'b0;
    end

    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign busy      = (state != IDLE);
    assign push      = commit && !full;
    assign pop       = out_valid && out_ready;
    assign out_note  = out_valid ? mem_note[rd_ptr] : '0;
    assign out_dur   = out_valid ? mem_dur[rd_ptr]  : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_note <= '0;
            cur_dur  <= '0;
            has_cur  <= 1'b0;
            cand     <= '0;
            cand_cnt <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= n_state;
            cur_note <= n_cur_note;
            cur_dur  <= n_cur_dur;
            has_cur  <= n_has;
            cand     <= n_cand;
            cand_cnt <= n_cnt;
            done     <= (state == TRACK) && stop;
            if (state == IDLE && start)
                overflow <= 1'b0;
            else if (commit && full)
                overflow <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_note[wr_ptr] <= cur_note;
            mem_dur[wr_ptr]  <= cur_dur;
        end
    end
endmodule

// File: tb/tb_note_event_tracker.sv
// Directed bench: four parameterisations share one stimulus stream.
module tb_note_event_tracker;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, fv = 1'b0, out_ready = 1'b0;
    logic [7:0] fn = '0;

    // a: defaults, b: DUR_W=4, c: DEPTH=4, d: KEEP_RESTS=1
    logic       vld_a, full_a, ovf_a, busy_a, done_a;
    logic [7:0] note_a, dur_a;
    logic [4:0] cnt_a;
    logic       vld_b, full_b, ovf_b, busy_b, done_b;
    logic [7:0] note_b;
    logic [3:0] dur_b;
    logic [4:0] cnt_b;
    logic       vld_c, full_c, ovf_c, busy_c, done_c;
    logic [7:0] note_c, dur_c;
    logic [2:0] cnt_c;
    logic       vld_d, full_d, ovf_d, busy_d, done_d;
    logic [7:0] note_d, dur_d;
    logic [4:0] cnt_d;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int done_base;

    always #5 clk = ~clk;
    always @(posedge clk) if (done_a) done_cnt <= done_cnt + 1;

    note_event_tracker u_a (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .frame_valid(fv),
        .frame_note(fn), .out_valid(vld_a), .out_ready(out_ready), .out_note(note_a),
        .out_dur(dur_a), .count(cnt_a), .full(full_a), .overflow(ovf_a), .busy(busy_a),
        .done(done_a));
    note_event_tracker #(.DUR_W(4)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .frame_valid(fv),
        .frame_note(fn), .out_valid(vld_b), .out_ready(out_ready), .out_note(note_b),
        .out_dur(dur_b), .count(cnt_b), .full(full_b), .overflow(ovf_b), .busy(busy_b),
        .done(done_b));
    note_event_tracker #(.DEPTH(4)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .frame_valid(fv),
        .frame_note(fn), .out_valid(vld_c), .out_ready(out_ready), .out_note(note_c),
        .out_dur(dur_c), .count(cnt_c), .full(full_c), .overflow(ovf_c), .busy(busy_c),
        .done(done_c));
    note_event_tracker #(.KEEP_RESTS(1)) u_d (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .frame_valid(fv),
        .frame_note(fn), .out_valid(vld_d), .out_ready(out_ready), .out_note(note_d),
        .out_dur(dur_d), .count(cnt_d), .full(full_d), .overflow(ovf_d), .busy(busy_d),
        .done(done_d));

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic go();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] note, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fv = 1'b1;
            fn = note;
        end
    endtask

    // Leaves the bench in the FLUSH cycle, where done is visible.
    task automatic halt();
        @(negedge clk);
        fv   = 1'b0;
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk) out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_vld", vld_a, 0);   chk("rst_cnt", cnt_a, 0);
        chk("rst_busy", busy_a, 0); chk("rst_ovf", ovf_a, 0);
        chk("rst_done", done_a, 0); chk("rst_full", full_a, 0);
        chk("rst_note", note_a, 0); chk("rst_dur", dur_a, 0);
        reset_n = 1'b1;

        // two clean runs
        done_base = done_cnt;
        go();
        chk("s1_busy", busy_a, 1);
        feed(60, 5); feed(62, 4);
        halt();
        chk("s1_done", done_a, 1);
        chk("s1_cnt", cnt_a, 2);
        @(negedge clk);
        chk("s1_done_lo", done_a, 0);
        chk("s1_busy_lo", busy_a, 0);
        chk("s1_ndone", done_cnt - done_base, 1);
        chk("s1_e0_note", note_a, 60); chk("s1_e0_dur", dur_a, 5);
        pop();
        chk("s1_e1_note", note_a, 62); chk("s1_e1_dur", dur_a, 4);
        chk("s1_cnt1", cnt_a, 1);
        pop();
        chk("s1_vld0", vld_a, 0);

        // glitch frame absorbed into surrounding run
        do_reset(); go();
        feed(60, 4); feed(61, 1); feed(60, 3);
        halt(); @(negedge clk);
        chk("s2_cnt", cnt_a, 1);
        chk("s2_note", note_a, 60); chk("s2_dur", dur_a, 7);

        // duration saturation splits the run (DUR_W=4)
        do_reset(); go();
        feed(60, 20);
        halt(); @(negedge clk);
        chk("s3_cnt_b", cnt_b, 2);
        chk("s3_e0_dur_b", dur_b, 15);
        chk("s3_a_dur", dur_a, 20);
        pop();
        chk("s3_e1_note_b", note_b, 60); chk("s3_e1_dur_b", dur_b, 5);

        // overflow with DEPTH=4 and no consumer
        do_reset(); go();
        for (int n = 10; n <= 15; n++) feed(8'(n), 3);
        halt(); @(negedge clk);
        chk("s4_cnt_c", cnt_c, 4);
        chk("s4_full_c", full_c, 1);
        chk("s4_ovf_c", ovf_c, 1);
        chk("s4_ovf_a", ovf_a, 0);
        chk("s4_head_c", note_c, 10);
        pop();
        chk("s4_next_c", note_c, 11);
        chk("s4_cnt_c1", cnt_c, 3);
        chk("s4_ovf_hold", ovf_c, 1);
        go();
        chk("s4_ovf_clr", ovf_c, 0);
        chk("s4_keep_c", note_c, 11);
        halt(); @(negedge clk);

        // rest handling: a drops rests, d keeps them
        do_reset(); go();
        feed(60, 3); feed(0, 3); feed(62, 3);
        halt(); @(negedge clk);
        chk("s5_cnt_a", cnt_a, 2); chk("s5_cnt_d", cnt_d, 3);
        chk("s5_a0", note_a, 60); chk("s5_d0", note_d, 60); chk("s5_d0_dur", dur_d, 3);
        pop();
        chk("s5_a1", note_a, 62); chk("s5_a1_dur", dur_a, 3);
        chk("s5_d1", note_d, 0);  chk("s5_d1_dur", dur_d, 3);
        pop();
        chk("s5_a_empty", vld_a, 0);
        chk("s5_d2", note_d, 62);

        // reset mid-session
        do_reset(); go();
        feed(60, 3); feed(61, 3); feed(62, 3);
        @(negedge clk);
        fv = 1'b0;
        chk("s6_cnt_pre", cnt_a, 2);
        chk("s6_busy_pre", busy_a, 1);
        reset_n = 1'b0;
        #1;
        chk("s6_vld", vld_a, 0);  chk("s6_cnt", cnt_a, 0);
        chk("s6_busy", busy_a, 0); chk("s6_ovf", ovf_a, 0);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        chk("s6_cnt_post", cnt_a, 0);
        done_base = done_cnt;
        halt(); @(negedge clk);
        chk("s6_stop_idle", cnt_a, 0);
        chk("s6_no_done", done_cnt - done_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
